cluster_rate_monitor: RTL and testbench
=======================================

# cluster_rate_monitor

Run-controlled monitor on the cluster-count stream of the trigger path, in the clock4x domain. It gates sampling of the per-bx cluster count and overflow flag over a programmable window of bunch crossings, then presents the accumulated statistics to slow control with a valid/ack handshake. Typical statistics are the total, the peak, the number of overflow bx and the number of bx above a threshold. It sits downstream of the cluster counter and upstream of the register/ipbus readout.

## Interface
Parameters:
- WINDOW_W, 16: width of window length and bx-tally counters.
- SUM_W, 24: width of saturating cluster sum.

Ports:
- clock4x  in  1  4x bx clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- bx_strobe_i  in  1  one clock4x pulse per bx; marks the cycle in which cnt_i/overflow_i are valid.
- cnt_i  in  11  cluster count for the current bx.
- overflow_i  in  1  overflow flag for the current bx.
- start_i  in  1  level-sampled pulse; arms a measurement.
- stop_i  in  1  pulse; aborts a running measurement.
- window_i  in  WINDOW_W  number of bx to sample; 0 is treated as 1; latched at start.
- thresh_i  in  11  high-count threshold; latched at start.
- ack_i  in  1  readout acknowledge.
- busy_o  out  1  high in ARM, RUN, DONE.
- valid_o  out  1  results stable and readable.
- aborted_o  out  1  result came from a stop_i abort; valid with valid_o.
- sum_o  out  SUM_W  sum of sampled cnt_i; saturates at all-ones.
- max_o  out  11  peak sampled cnt_i.
- ovf_bx_o  out  WINDOW_W  sampled bx with overflow_i=1.
- hi_bx_o  out  WINDOW_W  sampled bx with cnt_i > thresh_i (strict).

## Operation
- FSM states: IDLE, ARM, RUN, DONE.
- IDLE: start_i=1 and stop_i=0 latches window and threshold, clears accumulators, and moves to ARM. If start_i and stop_i are both high, stop wins and the FSM stays in IDLE.
- ARM: waits for bx_strobe_i. That strobe is the first sample; it is accumulated and the FSM enters RUN, or DONE if the window is 1. stop_i in ARM goes to DONE with aborted_o=1 and zero results.
- RUN: each bx_strobe_i accumulates and decrements the remaining count. On the strobe that makes the sample total equal to the window, the FSM goes to DONE. stop_i goes to DONE with aborted_o=1. If stop_i coincides with a strobe, that sample is accumulated first. start_i is ignored in RUN.
- DONE: valid_o=1 and outputs are frozen. ack_i returns to IDLE; valid_o and aborted_o drop, and data outputs hold their last values until the next start. start_i is ignored in DONE until ack is taken.
- Arithmetic:
  - sum accumulates cnt_i zero-extended to SUM_W and clamps at 2^SUM_W-1 (no wrap).
  - Tallies cannot exceed the window, so they never wrap.
  - A maximum window of 2^WINDOW_W-1 is legal.
- Reset mid-operation returns to IDLE with all outputs 0 immediately (asynchronous).

## Timing
- Reset values: busy_o, valid_o, aborted_o = 0; sum_o, max_o, ovf_bx_o, hi_bx_o = 0.
- All outputs are registered.
- busy_o rises the cycle after start_i is sampled in IDLE.
- valid_o rises the cycle after the final sampled strobe, or the cycle after stop_i is sampled.
- valid_o falls the cycle after ack_i is sampled in DONE. busy_o falls in the same cycle.
- Earliest restart: start_i in the cycle after valid_o falls.
- A strobe in the same cycle as start_i is not sampled; sampling begins with the next strobe in ARM.

## Configuration
- CLUSTER_MON_PEAK_EN:
  - Defined: max_o tracks the peak of sampled cnt_i.
  - Undefined: the peak comparator and register are not built and max_o is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Window of 4, strobes every 4 clocks, cnt_i = 3, 9, 0, 12, overflow_i high on bx 2 and 4, threshold 8 -> valid_o 1 cycle after the 4th strobe; sum_o=24, max_o=12, ovf_bx_o=2, hi_bx_o=2, aborted_o=0.
- window_i=0, single strobe with cnt_i=5 -> treated as window 1; sum_o=5, valid_o the cycle after that strobe.
- Window 100, stop_i after 10 strobes, with an 11th strobe coincident with stop_i -> aborted_o=1, results cover 11 samples.
- start_i and stop_i high together in IDLE -> busy_o stays 0 and no measurement runs. A later start_i alone -> busy_o=1 next cycle.
- SUM_W=8 override, window 10, cnt_i=40 each bx -> sum_o=255 (saturated), ovf_bx_o=0.
- Assert reset mid-RUN -> all outputs 0 asynchronously, FSM in IDLE. After reset release, start_i then ack handshake behaves normally. Repeat both builds: max_o=0 when CLUSTER_MON_PEAK_EN is undefined.

Source files
------------

// File: rtl/cluster_rate_monitor.sv
// Windowed cluster-count statistics with valid/ack readout, clock4x domain.
// Peak tracking on max_o is built only when CLUSTER_MON_PEAK_EN is defined.
module cluster_rate_monitor #(
    parameter int WINDOW_W = 16,
    parameter int SUM_W    = 24
) (
    input  logic                clock4x,
    input  logic                reset,
    input  logic                bx_strobe_i,
    input  logic [10:0]         cnt_i,
    input  logic                overflow_i,
    input  logic                start_i,
    input  logic                stop_i,
    input  logic [WINDOW_W-1:0] window_i,
    input  logic [10:0]         thresh_i,
    input  logic                ack_i,
    output logic                busy_o,
    output logic                valid_o,
    output logic                aborted_o,
    output logic [SUM_W-1:0]    sum_o,
    output logic [10:0]         max_o,
    output logic [WINDOW_W-1:0] ovf_bx_o,
    output logic [WINDOW_W-1:0] hi_bx_o
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t              state_q, state_d;
    logic [WINDOW_W-1:0] rem_q, rem_d;
    logic [10:0]         thr_q, thr_d;
    logic [SUM_W-1:0]    sum_d;
    logic [WINDOW_W-1:0] ovf_d, hi_d;
    logic                aborted_d;
    logic                sample;
    logic                clear;
    logic [SUM_W+11:0]   sum_add;

    // Wide add so any carry out of SUM_W bits means saturate.
    assign sum_add = {12'b0, sum_o} + {{(SUM_W+1){1'b0}}, cnt_i};

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        thr_d     = thr_q;
        sum_d     = sum_o;
        ovf_d     = ovf_bx_o;
        hi_d      = hi_bx_o;
        aborted_d = aborted_o;
        sample    = 1'b0;
        clear     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    state_d   = ARM;
                    rem_d     = (window_i == '0) ? WINDOW_W'(1) : window_i;
                    thr_d     = thresh_i;
                    clear     = 1'b1;
                    aborted_d = 1'b0;
                end
            end
            ARM: begin
                if (stop_i) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end else if (bx_strobe_i) begin
                    sample  = 1'b1;
                    rem_d   = rem_q - WINDOW_W'(1);
                    state_d = (rem_q == WINDOW_W'(1)) ? DONE : RUN;
                end
            end
            RUN: begin
                if (bx_strobe_i) begin
                    sample = 1'b1;
                    rem_d  = rem_q - WINDOW_W'(1);
                    if (rem_q == WINDOW_W'(1))
                        state_d = DONE;
                end
                if (stop_i) begin
                    state_d   = DONE;
                    aborted_d = 1'b1;
                end
            end
            DONE: begin
                if (ack_i) begin
                    state_d   = IDLE;
                    aborted_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear) begin
            sum_d = '0;
            ovf_d = '0;
            hi_d  = '0;
        end else if (sample) begin
            sum_d = (|sum_add[SUM_W+11:SUM_W]) ? '1 : sum_add[SUM_W-1:0];
            ovf_d = ovf_bx_o + WINDOW_W'(overflow_i);
            hi_d  = hi_bx_o + WINDOW_W'(cnt_i > thr_q);
        end
    end

    always_ff @(posedge clock4x or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            thr_q     <= '0;
            busy_o    <= 1'b0;
            valid_o   <= 1'b0;
            aborted_o <= 1'b0;
            sum_o     <= '0;
            ovf_bx_o  <= '0;
            hi_bx_o   <= '0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            thr_q     <= thr_d;
            busy_o    <= (state_d != IDLE);
            valid_o   <= (state_d == DONE);
            aborted_o <= aborted_d;
            sum_o     <= sum_d;
            ovf_bx_o  <= ovf_d;
            hi_bx_o   <= hi_d;
        end
    end

`ifdef CLUSTER_MON_PEAK_EN
    always_ff @(posedge clock4x or posedge reset) begin
        if (reset)
            max_o <= '0;
        else if (clear)
            max_o <= '0;
        else if (sample && (cnt_i > max_o))
            max_o <= cnt_i;
    end
`else
    assign max_o = '0;
`endif

endmodule

// File: tb/tb_cluster_rate_monitor.sv
// Bench for cluster_rate_monitor: directed table, corner sequences, random runs.
// A second instance with SUM_W=8 exercises sum saturation on the same stimulus.
module tb_cluster_rate_monitor;

`ifdef CLUSTER_MON_PEAK_EN
    localparam bit PEAK = 1'b1;
`else
    localparam bit PEAK = 1'b0;
`endif

    logic        clock4x = 1'b0;
    logic        reset = 1'b1;
    logic        bx_strobe_i = 1'b0;
    logic [10:0] cnt_i = '0;
    logic        overflow_i = 1'b0;
    logic        start_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [15:0] window_i = '0;
    logic [10:0] thresh_i = '0;
    logic        ack_i = 1'b0;

    logic        busy_o, valid_o, aborted_o;
    logic [23:0] sum_o;
    logic [10:0] max_o;
    logic [15:0] ovf_bx_o, hi_bx_o;

    logic        busy8, valid8, aborted8;
    logic [7:0]  sum8;
    logic [10:0] max8;
    logic [15:0] ovf8, hi8;

    int total = 0;
    int bad = 0;

    always #5 clock4x = ~clock4x;

    cluster_rate_monitor dut (
        .clock4x(clock4x), .reset(reset), .bx_strobe_i(bx_strobe_i),
        .cnt_i(cnt_i), .overflow_i(overflow_i), .start_i(start_i),
        .stop_i(stop_i), .window_i(window_i), .thresh_i(thresh_i),
        .ack_i(ack_i), .busy_o(busy_o), .valid_o(valid_o),
        .aborted_o(aborted_o), .sum_o(sum_o), .max_o(max_o),
        .ovf_bx_o(ovf_bx_o), .hi_bx_o(hi_bx_o)
    );

    cluster_rate_monitor #(.SUM_W(8)) dut8 (
        .clock4x(clock4x), .reset(reset), .bx_strobe_i(bx_strobe_i),
        .cnt_i(cnt_i), .overflow_i(overflow_i), .start_i(start_i),
        .stop_i(stop_i), .window_i(window_i), .thresh_i(thresh_i),
        .ack_i(ack_i), .busy_o(busy8), .valid_o(valid8),
        .aborted_o(aborted8), .sum_o(sum8), .max_o(max8),
        .ovf_bx_o(ovf8), .hi_bx_o(hi8)
    );

    typedef struct {
        int              win;
        int              thr;
        int              stop_after;
        int              gap;
        bit              rnd;
        logic [3:0][10:0] cnt;
        logic [3:0]      ovf;
        longint          e_sum;
        int              e_max;
        int              e_ovf;
        int              e_hi;
        bit              e_ab;
    } vec_t;

    vec_t tbl[7];

    task automatic tick();
        @(posedge clock4x);
        #1;
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(int win, int thr, int stp, int gap,
                                int c0, int c1, int c2, int c3,
                                logic [3:0] ovf, longint es, int emx,
                                int eo, int eh, bit ea);
        vec_t v;
        v.win = win; v.thr = thr; v.stop_after = stp; v.gap = gap;
        v.rnd = 1'b0;
        v.cnt[0] = 11'(c0); v.cnt[1] = 11'(c1);
        v.cnt[2] = 11'(c2); v.cnt[3] = 11'(c3);
        v.ovf = ovf; v.e_sum = es; v.e_max = emx;
        v.e_ovf = eo; v.e_hi = eh; v.e_ab = ea;
        return v;
    endfunction

    // One full measurement: start, strobes, optional stop, freeze check, ack.
    task automatic run(input vec_t v, input bit model);
        int     weff, n, c, o, emx, eo, eh;
        longint es, s24, s8;
        bit     ea;
        int     qc[$];
        int     qo[$];
        weff = (v.win == 0) ? 1 : v.win;
        n = (v.stop_after < 0) ? weff : v.stop_after;
        window_i = 16'(v.win);
        thresh_i = 11'(v.thr);
        start_i = 1'b1;
        bx_strobe_i = 1'b1;
        cnt_i = 11'd2000;
        overflow_i = 1'b1;
        tick();
        start_i = 1'b0;
        bx_strobe_i = 1'b0;
        overflow_i = 1'b0;
        chk("busy_rise", busy_o, 1);
        chk("valid_low_arm", valid_o, 0);
        if (n == 0) begin
            stop_i = 1'b1;
            tick();
            stop_i = 1'b0;
        end else begin
            for (int k = 1; k <= n; k++) begin
                repeat (v.gap - 1) tick();
                c = v.rnd ? int'($urandom_range(0, 2047)) : int'(v.cnt[(k-1)%4]);
                o = v.rnd ? int'($urandom_range(0, 1)) : int'(v.ovf[(k-1)%4]);
                if (k == n)
                    chk("valid_before_last", valid_o, 0);
                bx_strobe_i = 1'b1;
                cnt_i = 11'(c);
                overflow_i = o[0];
                stop_i = (k == n) && (v.stop_after > 0);
                qc.push_back(c);
                qo.push_back(o);
                tick();
                bx_strobe_i = 1'b0;
                stop_i = 1'b0;
                overflow_i = 1'b0;
                cnt_i = 11'($urandom_range(0, 2047));
            end
        end
        if (model) begin
            es = 0; emx = 0; eo = 0; eh = 0;
            foreach (qc[i]) begin
                es += qc[i];
                if (qc[i] > emx) emx = qc[i];
                eo += qo[i];
                if (qc[i] > v.thr) eh++;
            end
            ea = (v.stop_after >= 0);
        end else begin
            es = v.e_sum; emx = v.e_max; eo = v.e_ovf;
            eh = v.e_hi; ea = v.e_ab;
        end
        s24 = (es > 64'd16777215) ? 64'd16777215 : es;
        s8 = (es > 64'd255) ? 64'd255 : es;
        chk("valid_rise", valid_o, 1);
        chk("busy_done", busy_o, 1);
        chk("aborted", aborted_o, ea);
        chk("sum", sum_o, s24);
        chk("sum_w8", sum8, s8);
        chk("max", max_o, PEAK ? emx : 0);
        chk("ovf_bx", ovf_bx_o, eo);
        chk("hi_bx", hi_bx_o, eh);
        bx_strobe_i = 1'b1;
        cnt_i = 11'd2047;
        overflow_i = 1'b1;
        start_i = 1'b1;
        repeat (2) tick();
        bx_strobe_i = 1'b0;
        overflow_i = 1'b0;
        start_i = 1'b0;
        chk("frozen_valid", valid_o, 1);
        chk("frozen_sum", sum_o, s24);
        chk("frozen_ovf", ovf_bx_o, eo);
        ack_i = 1'b1;
        tick();
        ack_i = 1'b0;
        chk("valid_fall", valid_o, 0);
        chk("busy_fall", busy_o, 0);
        chk("aborted_fall", aborted_o, 0);
        chk("sum_hold", sum_o, s24);
        chk("hi_hold", hi_bx_o, eh);
    endtask

    initial begin
        vec_t rv;
        int   weff;
        tbl[0] = mk(4,   8,  -1, 4, 3,    9, 0, 12,   4'b1010, 24,   12,   2, 2, 0);
        tbl[1] = mk(0,   8,  -1, 3, 5,    0, 0, 0,    4'b0000, 5,    5,    0, 0, 0);
        tbl[2] = mk(100, 2,  11, 2, 7,    1, 2, 3,    4'b0001, 36,   7,    3, 5, 1);
        tbl[3] = mk(3,   0,  0,  1, 9,    9, 9, 9,    4'b1111, 0,    0,    0, 0, 1);
        tbl[4] = mk(5,   0,  -1, 1, 2047, 0, 1, 2047, 4'b1111, 6142, 2047, 5, 4, 0);
        tbl[5] = mk(1,   5,  -1, 2, 5,    0, 0, 0,    4'b0001, 5,    5,    1, 0, 0);
        tbl[6] = mk(10,  50, -1, 1, 40,   40, 40, 40, 4'b0000, 400,  40,   0, 0, 0);

        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_aborted", aborted_o, 0);
        chk("rst_sum", sum_o, 0);
        chk("rst_max", max_o, 0);
        chk("rst_ovf", ovf_bx_o, 0);
        chk("rst_hi", hi_bx_o, 0);
        tick();
        reset = 1'b0;
        tick();

        foreach (tbl[i])
            run(tbl[i], 1'b0);

        start_i = 1'b1;
        stop_i = 1'b1;
        window_i = 16'd4;
        tick();
        start_i = 1'b0;
        stop_i = 1'b0;
        chk("startstop_busy", busy_o, 0);
        bx_strobe_i = 1'b1;
        tick();
        bx_strobe_i = 1'b0;
        chk("startstop_idle", busy_o, 0);
        chk("startstop_valid", valid_o, 0);
        run(tbl[0], 1'b0);

        window_i = 16'd50;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) begin
            bx_strobe_i = 1'b1;
            cnt_i = 11'd600;
            overflow_i = 1'b1;
            tick();
        end
        bx_strobe_i = 1'b0;
        overflow_i = 1'b0;
        chk("midrun_busy", busy_o, 1);
        #3;
        reset = 1'b1;
        #1;
        chk("async_busy", busy_o, 0);
        chk("async_valid", valid_o, 0);
        chk("async_sum", sum_o, 0);
        chk("async_max", max_o, 0);
        chk("async_ovf", ovf_bx_o, 0);
        chk("async_hi", hi_bx_o, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", busy_o, 0);
        run(tbl[4], 1'b0);

        for (int it = 0; it < 25; it++) begin
            rv = tbl[0];
            rv.rnd = 1'b1;
            rv.win = $urandom_range(0, 12);
            weff = (rv.win == 0) ? 1 : rv.win;
            rv.thr = $urandom_range(0, 2047);
            rv.gap = $urandom_range(1, 3);
            rv.stop_after = ($urandom_range(0, 2) == 0) ?
                            int'($urandom_range(0, weff - 1)) : -1;
            run(rv, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
